// File: rtl/out_bcd_converter.sv
// out_bcd_converter: watches the CPU output word and, on every change, runs a
// serial double-dabble conversion. The last finished result (digits, leading
// zero mask, flags) is held stable while the next conversion runs.
module out_bcd_converter #(
   parameter int DATA_WIDTH = 16,
   parameter int DIGITS     = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank,
   output logic                  valid,
   output logic                  busy,
   output logic                  done
);

   localparam int BW = 4 * DIGITS;
   localparam int WW = BW + DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [WW-1:0]       work_q, work_d;
   logic [DATA_WIDTH-1:0] last_q, last_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                pending_q, pending_d;
   logic [BW-1:0]       bcd_q, bcd_d;
   logic [DIGITS-1:0]   blank_q, blank_d;
   logic                valid_q, valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [WW-1:0]       adj;
   logic [DIGITS-1:0]   mask;
   logic                hi_zero;

   // Add-3 correction on every BCD nibble >= 5, all in parallel; max result 12.
   always_comb begin
      adj = work_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (work_q[DATA_WIDTH+4*k +: 4] >= 4'd5)
            adj[DATA_WIDTH+4*k +: 4] = work_q[DATA_WIDTH+4*k +: 4] + 4'd3;
      end
   end

   // Leading-zero mask from the finished BCD field; the units digit always shows.
   always_comb begin
      mask    = '0;
      hi_zero = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         hi_zero = hi_zero & (work_q[DATA_WIDTH+4*k +: 4] == 4'd0);
         mask[k] = hi_zero;
      end
   end

   // Next-state and output logic; done is a one-cycle pulse by default-clear.
   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      bcd_d     = bcd_q;
      blank_d   = blank_q;
      valid_d   = valid_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pending_q || (in != last_q)) begin
               work_d    = {{BW{1'b0}}, in};
               last_d    = in;
               cnt_d     = '0;
               pending_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            work_d = {adj[WW-2:0], 1'b0};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(DATA_WIDTH - 1))
               state_d = S_DONE;
         end
         S_DONE: begin
            bcd_d   = work_q[WW-1 -: BW];
            blank_d = mask;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; synchronous reset aborts any conversion in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         work_q    <= '0;
         last_q    <= '0;
         cnt_q     <= '0;
         pending_q <= 1'b1;
         bcd_q     <= '0;
         blank_q   <= BLANK_RST;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         work_q    <= work_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         bcd_q     <= bcd_d;
         blank_q   <= blank_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bcd   = bcd_q;
   assign blank = blank_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_out_bcd_converter.sv
// Bench for out_bcd_converter: a transaction-level model (decimal arithmetic
// plus a cycle countdown) checked every cycle, and literal spot checks.
module tb_out_bcd_converter;

   localparam int DW = 16;
   localparam int DG = 5;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] in_s;
   logic [4*DG-1:0] bcd;
   logic [DG-1:0] blank;
   logic          valid, busy, done;

   int vectors     = 0;
   int miscompares = 0;

   out_bcd_converter #(.DATA_WIDTH(DW), .DIGITS(DG)) dut (
      .clk(clk), .rst_n(rst_n), .in(in_s),
      .bcd(bcd), .blank(blank), .valid(valid), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decimal digits by plain division.
   function automatic logic [4*DG-1:0] to_bcd(input int unsigned v);
      logic [4*DG-1:0] r;
      r = '0;
      for (int k = 0; k < DG; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Digit k blanked when value < 10^k (k >= 1).
   function automatic logic [DG-1:0] to_blank(input int unsigned v);
      logic [DG-1:0] r;
      int unsigned p;
      r = '0;
      p = 10;
      for (int k = 1; k < DG; k++) begin
         r[k] = (v < p);
         p = p * 10;
      end
      return r;
   endfunction

   // Model state
   logic            m_init = 1'b0;
   logic            m_pending;
   logic [DW-1:0]   m_last, m_cap;
   int              m_left;
   logic [4*DG-1:0] m_bcd;
   logic [DG-1:0]   m_blank;
   logic            m_valid, m_busy, m_done;

   // Model: a conversion takes DW+1 edges after the capture edge; idle compares.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_init = 1'b1; m_pending = 1'b1; m_last = '0; m_left = 0;
         m_bcd = '0; m_blank = 5'b11110; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      end else if (m_init) begin
         m_done = 1'b0;
         if (m_left == 0) begin
            if (m_pending || in_s != m_last) begin
               m_cap = in_s; m_last = in_s; m_pending = 1'b0;
               m_left = DW + 1; m_busy = 1'b1;
            end
         end else begin
            m_left--;
            if (m_left == 0) begin
               m_bcd = to_bcd(m_cap); m_blank = to_blank(m_cap);
               m_valid = 1'b1; m_busy = 1'b0; m_done = 1'b1;
            end
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (m_init) begin
         vectors++;
         if (bcd !== m_bcd || blank !== m_blank || valid !== m_valid ||
             busy !== m_busy || done !== m_done) begin
            miscompares++;
            $display("FAIL cycle t=%0t: got bcd=%h blank=%b v=%b b=%b d=%b, need bcd=%h blank=%b v=%b b=%b d=%b",
                     $time, bcd, blank, valid, busy, done,
                     m_bcd, m_blank, m_valid, m_busy, m_done);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, need %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Apply a new idle value and check the result 18 edges later.
   task automatic convert(input logic [DW-1:0] v, input logic [19:0] eb, input logic [4:0] ek);
      in_s = v;
      step(17);
      chk("hold_old", 32'(done), 32'(0));
      step(1);
      chk("bcd", 32'(bcd), 32'(eb));
      chk("blank", 32'(blank), 32'(ek));
      chk("done", 32'(done), 32'(1));
      step(1);
   endtask

   initial begin
      rst_n = 1'b0; in_s = '0;
      step(2);
      chk("rst_bcd", 32'(bcd), 32'(0));
      chk("rst_blank", 32'(blank), 32'(5'b11110));
      chk("rst_valid", 32'(valid), 32'(0));
      rst_n = 1'b1;
      step(1);
      chk("pend_busy", 32'(busy), 32'(1));
      step(17);
      chk("first_bcd", 32'(bcd), 32'(0));
      chk("first_blank", 32'(blank), 32'(5'b11110));
      chk("first_valid", 32'(valid), 32'(1));
      chk("first_done", 32'(done), 32'(1));
      step(1);
      chk("done_pulse", 32'(done), 32'(0));

      convert(16'd12345, 20'h12345, 5'b00000);
      convert(16'd65535, 20'h65535, 5'b00000);
      convert(16'd7,     20'h00007, 5'b11110);
      convert(16'd100,   20'h00100, 5'b11000);

      // Change during SHIFT: only the latest value is converted afterwards.
      convert(16'd0, 20'h00000, 5'b11110);
      in_s = 16'd100;
      step(6);
      in_s = 16'd150;
      step(2);
      in_s = 16'd200;
      step(10);
      chk("chg_first", 32'(bcd), 32'(20'h00100));
      chk("chg_done", 32'(done), 32'(1));
      step(1);
      chk("chg_rebusy", 32'(busy), 32'(1));
      step(17);
      chk("chg_second", 32'(bcd), 32'(20'h00200));

      // Reset mid-conversion, then pending forces reconversion.
      step(1);
      in_s = 16'd999;
      step(8);
      rst_n = 1'b0;
      step(1);
      chk("mid_rst_bcd", 32'(bcd), 32'(0));
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_valid", 32'(valid), 32'(0));
      chk("mid_rst_blank", 32'(blank), 32'(5'b11110));
      rst_n = 1'b1;
      step(18);
      chk("re999_bcd", 32'(bcd), 32'(20'h00999));
      chk("re999_blank", 32'(blank), 32'(5'b11000));

      // Quiet input: nothing should move.
      step(100);
      chk("quiet_busy", 32'(busy), 32'(0));
      chk("quiet_done", 32'(done), 32'(0));
      chk("quiet_bcd", 32'(bcd), 32'(20'h00999));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/out_bcd_converter.md
# out_bcd_converter

Sequential binary-to-BCD converter sitting directly downstream of the CPU's `out` port. It watches the CPU output word, and whenever the value changes it runs a shift-and-add-3 (double-dabble) conversion, then presents packed BCD digits, a leading-zero blanking mask and status flags to the display driver stage. The previous result is held stable while a new conversion runs, so the display never shows intermediate values.

## Interface

Parameters:
- `DATA_WIDTH`, 16, width of the binary input word; matches the CPU data width.
- `DIGITS`, 5, number of BCD digits produced; must satisfy 10^DIGITS > 2^DATA_WIDTH − 1.

Ports:
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst_n`  input  1  reset, synchronous and active-low; sampled on the rising edge of `clk`.
- `in`  input  DATA_WIDTH  unsigned binary value; connected to CPU `out`.
- `bcd`  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0], digit k in [4k+3:4k].
- `blank`  output  DIGITS  bit k = 1 when digit k is a leading zero; bit 0 is always 0.
- `valid`  output  1  1 once at least one conversion has completed since reset.
- `busy`  output  1  1 while a conversion is in progress.
- `done`  output  1  one-cycle pulse in the cycle after `bcd` is updated.

## Operation

- Internal registers:
  - `work`: 4*DIGITS + DATA_WIDTH bits, BCD field on top, binary field below.
  - `last`: DATA_WIDTH bits, the last value captured.
  - `cnt`: shift counter, clog2(DATA_WIDTH+1) bits.
  - `pending`: forces one conversion after reset.
- IDLE:
  - Start a conversion when `pending` = 1, or when `in` != `last`.
  - On start: `work` <= {zeros, `in`}, `last` <= `in`, `cnt` <= 0, `pending` <= 0, `busy` <= 1, go to SHIFT.
  - Otherwise hold all state.
- SHIFT:
  - Each cycle, add 3 to every BCD nibble of `work` whose value is ≥ 5. All nibbles are adjusted in parallel, combinationally. Then shift the whole `work` register left by 1.
  - Increment `cnt`.
  - When the step just performed is step DATA_WIDTH (`cnt` = DATA_WIDTH−1 before the increment), go to DONE.
- DONE:
  - `bcd` <= BCD field of `work`.
  - `blank` <= computed leading-zero mask. Digit k is blanked when it and all higher digits are 0, for k ≥ 1; digit 0 is never blanked.
  - `valid` <= 1, `busy` <= 0, `done` <= 1, go to IDLE.
- `done` is cleared in every state other than the DONE transition, so it is high for exactly one cycle.
- Changes on `in` during SHIFT/DONE are not sampled. After returning to IDLE, `in` is compared against `last`; if it differs, a new conversion starts in the first IDLE cycle. Only the most recent value is ever converted; intermediate values are dropped.
- Arithmetic: unsigned only. All adjusted nibbles stay ≤ 12 before the shift, so no carry crosses a nibble boundary. The top binary bit shifts out and is discarded.

## Timing

- Reset (`rst_n` = 0 at a rising edge):
  - State IDLE.
  - `bcd` = 0, `blank` = {DIGITS−1 ones, 0}, `valid` = 0, `busy` = 0, `done` = 0.
  - `last` = 0, `pending` = 1.
  - Reset mid-conversion aborts immediately and discards the partial result.
- Latency: let E0 be the capture edge in IDLE.
  - SHIFT occupies edges E1..E_DATA_WIDTH.
  - `bcd`/`blank`/`valid` update at edge E_DATA_WIDTH+1 (E17 by default), with `done` high in the cycle following that edge.
  - If `in` changes while idle, it is captured at the next edge. Result appears DATA_WIDTH+2 edges after the change (18 by default).
- `busy` is high from E0+ through E_DATA_WIDTH+1 (exclusive), i.e. DATA_WIDTH+1 cycles.
- Back-to-back throughput: one conversion per DATA_WIDTH+2 cycles.
- First conversion after reset happens even when `in` = 0, driven by `pending`.

## Test plan

- Reset with `in` = 0, release `rst_n` → `busy` rises at the next edge; 17 edges later `bcd` = 0x00000, `blank` = 5'b11110, `valid` = 1, `done` pulses exactly one cycle.
- Idle, set `in` = 12345 → `bcd` = 0x12345, `blank` = 5'b00000, 18 edges after the change; `bcd` holds the old value until then.
- `in` = 65535 (max) → `bcd` = 0x65535; `in` = 7 → `bcd` = 0x00007, `blank` = 5'b11110; `in` = 100 → `blank` = 5'b11000.
- `in` = 100, then change to 200 five cycles into SHIFT → first result 0x00100 with `done`, then `busy` reasserts on the first IDLE cycle; second result 0x00200. The intermediate value 150, if applied and removed within SHIFT, never appears.
- Assert `rst_n` = 0 for one edge in the middle of converting 999 → all outputs return to reset values at that edge. After release, 999 is reconverted (because of `pending`) and yields 0x00999.
- Hold `in` constant for 100 cycles after a conversion → `busy` stays 0, `done` never pulses, `bcd` is unchanged.
